// File: rtl/image_stream_loader_if.sv
// image_stream_loader_if: stream-in / image-out bundle between a word source, the loader and the classifier
// slave  : loader view (consumes s_valid/s_data/image_ready, drives everything else)
// master : source/classifier view (the mirror image)
interface image_stream_loader_if #(
  parameter int ROWS = 28,
  parameter int COLS = 28,
  parameter int DW   = 32
);
  logic                        s_valid;
  logic                        s_ready;
  logic [DW-1:0]               s_data;
  logic [0:ROWS-1][0:COLS-1]   image_out;
  logic                        image_valid;
  logic                        image_ready;
  logic [1:0]                  kernel_layer;
  logic [1:0]                  offset_layer;
  logic                        hdr_err;
  logic [15:0]                 img_count;
  modport slave (
    input  s_valid, s_data, image_ready,
    output s_ready, image_out, image_valid, kernel_layer, offset_layer, hdr_err, img_count
  );
  modport master (
    output s_valid, s_data, image_ready,
    input  s_ready, image_out, image_valid, kernel_layer, offset_layer, hdr_err, img_count
  );
endinterface

// File: rtl/image_stream_loader.sv
// image_stream_loader: parses a word stream into image packets (handed to the classifier) and parameter writes
// clk, rst_n : clock, synchronous active-low reset
// bus.s_*    : input word stream (valid/ready)
// bus.image_*: image handoff; image_out doubles as the parameter bus while a kernel/offset strobe is high
// bus.kernel_layer/offset_layer : one-cycle write strobes carrying the target layer
// bus.hdr_err: sticky bad-header flag, bus.img_count: images handed off
module image_stream_loader #(
  parameter int ROWS = 28,
  parameter int COLS = 28,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  image_stream_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, IMG_ROWS, IMG_PRESENT, PRM_DATA, PRM_ADDR, PRM_WRITE} state_t;
  state_t                    state, nxt;
  logic [4:0]                row_cnt;
  logic [0:ROWS-1][0:COLS-1] img_q, prm_bus;
  logic [1:0]                ptype, player;
  logic [24:0]               kern;
  logic [8:0]                num;
  logic [27:0]               addr;
  logic [15:0]               cnt;
  logic                      err;
  logic [1:0]                htype, hlayer;
  logic                      beat, hdr_img, hdr_prm, last_row;
  assign htype    = bus.s_data[31:30];
  assign hlayer   = bus.s_data[29:28];
  assign beat     = bus.s_valid && bus.s_ready;
  assign hdr_img  = htype == 2'd0;
  // a parameter write to layer 0 has no target, so it is treated as a bad header
  assign hdr_prm  = (htype == 2'd1 || htype == 2'd2) && hlayer != 2'd0;
  assign last_row = row_cnt == 5'(ROWS - 1);
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:        nxt = !beat ? IDLE : hdr_img ? IMG_ROWS : hdr_prm ? PRM_DATA : IDLE;
      IMG_ROWS:    nxt = beat && last_row ? IMG_PRESENT : IMG_ROWS;
      IMG_PRESENT: nxt = bus.image_ready ? IDLE : IMG_PRESENT;
      PRM_DATA:    nxt = beat ? PRM_ADDR : PRM_DATA;
      PRM_ADDR:    nxt = beat ? PRM_WRITE : PRM_ADDR;
      PRM_WRITE:   nxt = IDLE;
      default:     nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      row_cnt <= '0;
      img_q   <= '0;
      ptype   <= '0;
      player  <= '0;
      kern    <= '0;
      num     <= '0;
      addr    <= '0;
      cnt     <= '0;
      err     <= 1'b0;
    end else begin
      if (state == IDLE && beat) begin
        ptype   <= htype;
        player  <= hlayer;
        row_cnt <= '0;
        if (!hdr_img && !hdr_prm) err <= 1'b1;
      end
      if (state == IMG_ROWS && beat) begin
        for (int c = 0; c < COLS; c++) img_q[row_cnt][c] <= bus.s_data[c];
        row_cnt <= row_cnt + 5'd1;
      end
      if (state == IMG_PRESENT && bus.image_ready) cnt <= cnt + 16'd1;
      if (state == PRM_DATA && beat) begin
        kern <= bus.s_data[24:0];
        num  <= bus.s_data[8:0];
      end
      if (state == PRM_ADDR && beat) addr <= bus.s_data[27:0];
    end
  // parameter bus layout: kernel in row 0, number in row 3, address fields in rows 4..8
  always_comb begin
    prm_bus = '0;
    for (int i = 0; i < 25; i++) prm_bus[0][i] = kern[i];
    for (int i = 0; i < 9; i++)  prm_bus[3][i] = num[i];
    for (int i = 0; i < 5; i++)  prm_bus[4][i] = addr[i];
    for (int i = 0; i < 3; i++)  prm_bus[5][i] = addr[5+i];
    for (int i = 0; i < 4; i++)  prm_bus[6][i] = addr[8+i];
    for (int i = 0; i < 6; i++)  prm_bus[7][i] = addr[12+i];
    for (int i = 0; i < 10; i++) prm_bus[8][i] = addr[18+i];
  end
  always_comb begin
    bus.s_ready      = state == IDLE || state == IMG_ROWS || state == PRM_DATA || state == PRM_ADDR;
    bus.image_valid  = state == IMG_PRESENT;
    bus.kernel_layer = state == PRM_WRITE && ptype == 2'd1 ? player : 2'd0;
    bus.offset_layer = state == PRM_WRITE && ptype == 2'd2 ? player : 2'd0;
    bus.image_out    = state == PRM_WRITE ? prm_bus : img_q;
    bus.hdr_err      = err;
    bus.img_count    = cnt;
  end
endmodule

// File: tb/tb_image_stream_loader.sv
// tb_image_stream_loader: randomized self-checking bench for image_stream_loader against a packet-level model
module tb_image_stream_loader;
  localparam int ROWS = 28;
  localparam int COLS = 28;
  localparam int DW   = 32;
  typedef logic [0:ROWS-1][0:COLS-1] img_t;
  typedef struct {logic [1:0] k; logic [1:0] o; img_t img;} strobe_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  image_stream_loader_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) bus();
  image_stream_loader #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  img_t exp_img;
  logic [15:0] exp_cnt;
  logic exp_err;
  strobe_t strobes[$];
  always @(negedge clk)
    if (bus.kernel_layer != 2'd0 || bus.offset_layer != 2'd0)
      strobes.push_back('{k: bus.kernel_layer, o: bus.offset_layer, img: bus.image_out});
  function automatic img_t prm_img(input logic [24:0] kern, input logic [8:0] num, input logic [31:0] a);
    img_t m = '0;
    int unsigned f18 = a % 32;
    int unsigned f5 = (a / 32) % 8;
    int unsigned f10 = (a / 256) % 16;
    int unsigned f60 = (a / 4096) % 64;
    int unsigned f960 = (a / 262144) % 1024;
    for (int i = 0; i < 25; i++) m[0][i] = kern[i];
    for (int i = 0; i < 9; i++) m[3][i] = num[i];
    for (int i = 0; i < 10; i++) begin
      if (i < 5) m[4][i] = 1'(f18 >> i);
      if (i < 3) m[5][i] = 1'(f5 >> i);
      if (i < 4) m[6][i] = 1'(f10 >> i);
      if (i < 6) m[7][i] = 1'(f60 >> i);
      m[8][i] = 1'(f960 >> i);
    end
    return m;
  endfunction
  task automatic send(input logic [31:0] d);
    int n = 0;
    int k = $urandom_range(0, 2);
    repeat (k) begin
      bus.s_valid = 1'b0;
      bus.s_data = $urandom;
      @(negedge clk);
    end
    bus.s_valid = 1'b1;
    bus.s_data = d;
    while (bus.s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL s_ready_timeout: waited %0d cycles, required s_ready=1", n);
    end
    @(posedge clk);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    bus.image_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_img = '0;
    exp_cnt = '0;
    exp_err = 1'b0;
    strobes.delete();
  endtask
  task automatic send_rows(input bit diag, input int n);
    logic [31:0] d;
    send({2'b00, 2'($urandom), 28'($urandom)});
    for (int r = 0; r < n; r++) begin
      d = diag ? ((32'd1 << r) | ({$urandom} << 28)) : $urandom;
      for (int c = 0; c < COLS; c++) exp_img[r][c] = d[c];
      if (r == ROWS - 1) begin
        checks++;
        if (bus.image_valid !== 1'b0) begin
          errors++;
          $display("FAIL early_valid: image_valid=%b before last row, required 0", bus.image_valid);
        end
      end
      send(d);
    end
  endtask
  task automatic send_image(input bit diag, input int hold);
    strobes.delete();
    bus.image_ready = (hold == 0);
    send_rows(diag, ROWS);
    checks++;
    if (bus.image_valid !== 1'b1) begin
      errors++;
      $display("FAIL valid_rise: image_valid=%b after last row, required 1", bus.image_valid);
    end
    checks++;
    if (bus.image_out !== exp_img) begin
      errors++;
      $display("FAIL image_data: got %h required %h", bus.image_out, exp_img);
    end
    for (int i = 0; i < hold; i++) begin
      checks++;
      if (bus.image_valid !== 1'b1 || bus.s_ready !== 1'b0 || bus.image_out !== exp_img) begin
        errors++;
        $display("FAIL hold_stable cycle %0d: valid=%b s_ready=%b image_ok=%b, required 1 0 1",
                 i, bus.image_valid, bus.s_ready, bus.image_out === exp_img);
      end
      bus.s_valid = 1'($urandom);
      bus.s_data = $urandom;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.image_ready = 1'b1;
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    checks++;
    if (bus.image_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_fall: image_valid=%b after handoff, required 0", bus.image_valid);
    end
    checks++;
    if (bus.img_count !== exp_cnt) begin
      errors++;
      $display("FAIL img_count: got %0d required %0d", bus.img_count, exp_cnt);
    end
    checks++;
    if (strobes.size() != 0) begin
      errors++;
      $display("FAIL image_strobe: %0d strobe cycles during image packet, required 0", strobes.size());
    end
  endtask
  task automatic send_param(input logic [1:0] t, input logic [1:0] l, input logic [31:0] data, input logic [31:0] a);
    strobe_t s;
    img_t pe;
    strobes.delete();
    send({t, l, 28'($urandom)});
    send(data);
    send(a);
    repeat (2) @(negedge clk);
    pe = prm_img(data[24:0], data[8:0], a);
    checks++;
    if (strobes.size() != 1) begin
      errors++;
      $display("FAIL strobe_count: got %0d strobe cycles required 1", strobes.size());
    end
    if (strobes.size() >= 1) begin
      s = strobes[0];
      checks++;
      if (s.k !== (t == 2'd1 ? l : 2'd0) || s.o !== (t == 2'd2 ? l : 2'd0)) begin
        errors++;
        $display("FAIL strobe_layer: kernel=%0d offset=%0d required %0d %0d",
                 s.k, s.o, t == 2'd1 ? l : 2'd0, t == 2'd2 ? l : 2'd0);
      end
      checks++;
      if (s.img !== pe) begin
        errors++;
        $display("FAIL param_bus: got %h required %h", s.img, pe);
      end
    end
    checks++;
    if (bus.image_out !== exp_img) begin
      errors++;
      $display("FAIL buffer_kept: got %h required %h", bus.image_out, exp_img);
    end
    checks++;
    if (bus.s_ready !== 1'b1 || bus.hdr_err !== exp_err) begin
      errors++;
      $display("FAIL after_param: s_ready=%b hdr_err=%b required 1 %b", bus.s_ready, bus.hdr_err, exp_err);
    end
  endtask
  task automatic send_bad(input logic [31:0] hdr);
    strobes.delete();
    send(hdr);
    exp_err = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.hdr_err !== 1'b1 || bus.s_ready !== 1'b1 || strobes.size() != 0) begin
      errors++;
      $display("FAIL bad_header: hdr_err=%b s_ready=%b strobes=%0d required 1 1 0",
               bus.hdr_err, bus.s_ready, strobes.size());
    end
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.s_ready !== 1'b1 || bus.image_valid !== 1'b0 || bus.kernel_layer !== 2'd0 ||
        bus.offset_layer !== 2'd0 || bus.hdr_err !== 1'b0 || bus.img_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_ctrl: s_ready=%b valid=%b k=%0d o=%0d err=%b cnt=%0d required 1 0 0 0 0 0",
               bus.s_ready, bus.image_valid, bus.kernel_layer, bus.offset_layer, bus.hdr_err, bus.img_count);
    end
    checks++;
    if (bus.image_out !== img_t'(0)) begin
      errors++;
      $display("FAIL reset_image: got %h required 0", bus.image_out);
    end
  endtask
  task automatic test_image();
    send_image(1'b1, 0);
  endtask
  task automatic test_backpressure();
    send_image(1'b1, 10);
  endtask
  task automatic test_kernel();
    send_param(2'd1, 2'd2, {7'($urandom), 25'h1FFFFFF}, {4'($urandom), 28'(5 | (33 << 12))});
  endtask
  task automatic test_hdr_err();
    send_bad({2'b11, 2'($urandom), 28'($urandom)});
    send_param(2'd2, 2'd1, {7'($urandom), 16'($urandom), 9'h07F}, $urandom);
    send_bad({2'b01, 2'b00, 28'($urandom)});
    send_image(1'b0, 2);
  endtask
  task automatic test_reset_mid();
    do_reset();
    send_rows(1'b0, 14);
    do_reset();
    checks++;
    if (bus.image_valid !== 1'b0 || bus.img_count !== 16'd0 || bus.image_out !== img_t'(0)) begin
      errors++;
      $display("FAIL reset_mid_rows: valid=%b cnt=%0d image_zero=%b required 0 0 1",
               bus.image_valid, bus.img_count, bus.image_out === img_t'(0));
    end
    send_image(1'b0, $urandom_range(0, 3));
    bus.image_ready = 1'b0;
    send_rows(1'b0, ROWS);
    do_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.image_valid !== 1'b0 || bus.img_count !== 16'd0 || bus.image_out !== img_t'(0)) begin
      errors++;
      $display("FAIL reset_present: valid=%b cnt=%0d image_zero=%b required 0 0 1",
               bus.image_valid, bus.img_count, bus.image_out === img_t'(0));
    end
    send({2'b10, 2'b11, 28'($urandom)});
    send($urandom);
    do_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (strobes.size() != 0 || bus.hdr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_param: strobes=%0d hdr_err=%b required 0 0", strobes.size(), bus.hdr_err);
    end
  endtask
  task automatic test_random();
    logic [1:0] t, l;
    for (int p = 0; p < 40; p++) begin
      t = 2'($urandom);
      l = 2'($urandom);
      if (t == 2'd0) send_image(1'b0, $urandom_range(0, 4));
      else if (t == 2'd3 || l == 2'd0) send_bad({t, l, 28'($urandom)});
      else send_param(t, l, $urandom, $urandom);
    end
  endtask
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.image_ready = 1'b0;
    exp_img = '0;
    exp_cnt = '0;
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_image();
    test_backpressure();
    test_kernel();
    test_hdr_err();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/image_stream_loader.md
IMAGE_STREAM_LOADER -- requirements
Module: image_stream_loader

Interface
REQ-001 SHALL have parameter ROWS, default 28: image rows per image packet.
REQ-002 SHALL have parameter COLS, default 28: bits per image row; COLS <= DW.
REQ-003 SHALL have parameter DW, default 32: stream word width.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port s_valid, input, 1: stream word valid.
REQ-007 SHALL have port s_ready, output, 1: loader accepts word; a beat transfers when s_valid && s_ready.
REQ-008 SHALL have port s_data, input, DW: stream word.
REQ-009 SHALL have port image_out, output, [0:ROWS-1][0:COLS-1] bits: bus to classifier top.
REQ-010 SHALL have port image_valid, output, 1: image on image_out is complete.
REQ-011 SHALL have port image_ready, input, 1: classifier accepts image.
REQ-012 SHALL have port kernel_layer, output, 2: kernel write strobe/select (0 = none, 1 = conv1, 2 = conv2, 3 = fc).
REQ-013 SHALL have port offset_layer, output, 2: offset write strobe/select, same encoding.
REQ-014 SHALL have port hdr_err, output, 1: sticky bad-header flag.
REQ-015 SHALL have port img_count, output, 16: count of images handed off; wraps 0xFFFF -> 0.

Function
REQ-016 Packet header word: s_data[31:30] = type (0 image, 1 kernel, 2 offset, 3 illegal); s_data[29:28] = layer.
REQ-017 Image packet SHALL be header + ROWS beats; beat r stores s_data[c] into image bit [r][c], c = 0..COLS-1.
REQ-018 Parameter packet SHALL be header + DATA beat + ADDR beat.
REQ-019 DATA beat: s_data[24:0] = kernel bits; s_data[8:0] = number.
REQ-020 ADDR beat: addr18 = [4:0], addr5 = [7:5], addr10 = [11:8], addr60 = [17:12], addr960 = [27:18].
REQ-021 FSM states: IDLE, IMG_ROWS, IMG_PRESENT, PRM_DATA, PRM_ADDR, PRM_WRITE.
REQ-022 IDLE: accepted header goes to IMG_ROWS (type 0) or PRM_DATA (type 1/2, layer != 0); otherwise hdr_err <= 1 and stay IDLE.
REQ-023 IMG_ROWS: 5-bit row counter from 0; after beat ROWS-1 is accepted, go to IMG_PRESENT.
REQ-024 IMG_PRESENT: image_valid = 1, held with image_out stable until image_ready = 1; that cycle img_count increments and state returns to IDLE.
REQ-025 image_valid SHALL rise the cycle after the last row beat is accepted.
REQ-026 PRM_DATA -> PRM_ADDR -> PRM_WRITE, each on an accepted beat.
REQ-027 PRM_WRITE SHALL last exactly one cycle, then IDLE.
REQ-028 In PRM_WRITE, kernel_layer = layer (type 1) or offset_layer = layer (type 2); the other strobe is 0.
REQ-029 kernel_layer and offset_layer SHALL be 0 in every state except PRM_WRITE.
REQ-030 In PRM_WRITE, image_out SHALL carry the parameter bus; all other bits are 0:
- image[0][c] = kernel bit c (c = 0..24);
- image[3][i] = number bit i (i = 0..8);
- image[4][4:0] = addr18, image[5][2:0] = addr5, image[6][3:0] = addr10, image[7][5:0] = addr60, image[8][9:0] = addr960.
REQ-031 Outside PRM_WRITE, image_out SHALL show the image buffer; parameter packets SHALL NOT alter the buffer.
REQ-032 s_ready SHALL be 1 in IDLE, IMG_ROWS, PRM_DATA and PRM_ADDR, and 0 in IMG_PRESENT and PRM_WRITE.
REQ-033 s_ready SHALL be combinational from state only.
REQ-034 Image buffer bits at or above bit COLS of s_data, and bits [31:28] of the ADDR beat, SHALL be ignored.
REQ-035 Gaps in s_valid at any point SHALL stall the FSM without loss.

Reset
REQ-036 When rst_n = 0 at a clock edge:
- state -> IDLE; partial packet discarded;
- row counter, image buffer, img_count, hdr_err -> 0;
- image_valid, kernel_layer, offset_layer -> 0; s_ready -> 1 the following cycle.
REQ-037 Reset asserted mid-packet or during IMG_PRESENT SHALL drop the packet; no strobe or handoff SHALL occur.

Verification
REQ-038 Image packet of 28 rows with row r = 1 << r, image_ready tied 1 -> image_valid high for 1 cycle; image_out[r][r] = 1, all else 0; img_count = 1.
REQ-039 Same image with image_ready held 0 for 10 cycles -> image_valid and image_out stable for 10 cycles, s_ready = 0 throughout; handoff on the cycle image_ready = 1.
REQ-040 Kernel packet (layer 2, kernel 0x1FFFFFF, addr18 = 5, addr60 = 33) -> exactly one cycle with kernel_layer = 2, image[0][0:24] all 1, image[4] = 5, image[7] = 33; offset_layer = 0.
REQ-041 Header type 3, then a valid offset packet (layer 1, number = 0x07F) -> hdr_err = 1 and stays 1; offset_layer = 1 for one cycle with image[3][6:0] all 1.
REQ-042 rst_n pulsed low after row 13 of an image, then a full image sent -> no image_valid before the new packet; rows 14..27 of the new image are correct; img_count = 1.
